// File: rtl/mac_16_scheduler.sv
// Tile scheduler for a 16-row MAC array: clears the accumulators, streams
// ksteps*16 operand reads through the array, then holds the result for handoff.
module mac_16_scheduler #(
  parameter int KSTEP_W = 8,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [KSTEP_W-1:0] cmd_ksteps,
  output logic               buf_rd_en,
  output logic [ADDR_W-1:0]  buf_rd_addr,
  output logic               mac_rst_n,
  output logic               mac_is_int8_mode,
  output logic               mac_is_int4_mode,
  output logic               mac_is_vsq,
  output logic [3:0]         mac_slot,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               done,
  output logic               err_illegal,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    MODE_INT8 = 2'b00,
    MODE_INT4 = 2'b01,
    MODE_VSQ  = 2'b10,
    MODE_BAD  = 2'b11
  } mode_t;

  state_t             state_q, state_d;
  mode_t              mode_q;
  logic [KSTEP_W-1:0] ksteps_q;
  logic [KSTEP_W-1:0] kstep_q, kstep_d;
  logic [3:0]         slot_q, slot_d;
  logic               mac_rst_n_q;
  logic               err_q;

  logic cmd_legal;
  logic accept;
  logic reject;
  logic in_run;
  logic last_kstep;
  logic final_run;
  logic run_read;

  assign cmd_legal  = (mode_t'(cmd_mode) != MODE_BAD) && (cmd_ksteps != '0);
  assign last_kstep = (kstep_q == ksteps_q - KSTEP_W'(1));
  assign in_run     = (state_q == S_RUN);
  assign final_run  = in_run && (slot_q == 4'd15) && last_kstep;
  assign run_read   = in_run && !final_run;

  // The slot counter doubles as the CLEAR timer so the clear window spans
  // exactly one full slot period of the array.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    kstep_d = kstep_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      S_IDLE: begin
        slot_d  = '0;
        kstep_d = '0;
        if (cmd_valid) begin
          if (cmd_legal) begin
            accept  = 1'b1;
            state_d = S_CLEAR;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        slot_d = slot_q + 4'd1;
        if (slot_q == 4'd15) state_d = S_FILL;
      end
      S_FILL: state_d = S_RUN;
      S_RUN: begin
        slot_d = slot_q + 4'd1;
        if (slot_q == 4'd15) begin
          kstep_d = kstep_q + KSTEP_W'(1);
          if (last_kstep) begin
            kstep_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      kstep_q     <= '0;
      mode_q      <= MODE_INT8;
      ksteps_q    <= '0;
      mac_rst_n_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      kstep_q     <= kstep_d;
      mac_rst_n_q <= (state_d != S_CLEAR);
      err_q       <= reject;
      if (accept) begin
        mode_q   <= mode_t'(cmd_mode);
        ksteps_q <= cmd_ksteps;
      end
    end
  end

  // During RUN the address leads mac_slot by one to cover the buffer latency.
  assign buf_rd_en   = (state_q == S_FILL) || run_read;
  assign buf_rd_addr = run_read ? ADDR_W'({kstep_q, slot_q}) + ADDR_W'(1) : '0;

  assign mac_rst_n        = mac_rst_n_q;
  assign mac_is_int8_mode = in_run && (mode_q == MODE_INT8);
  assign mac_is_int4_mode = in_run && (mode_q == MODE_INT4);
  assign mac_is_vsq       = in_run && (mode_q == MODE_VSQ);
  assign mac_slot         = in_run ? slot_q : 4'd0;

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_DRAIN);
  assign done        = (state_q == S_DRAIN) && res_ready;
  assign err_illegal = err_q;

endmodule
